// File: rtl/hazard_unit_param_pkg.sv
// Shared types for the parametrised LC-3b operand-hazard unit.
//   lc3b_hz_state : load-use stall FSM states
//   fwd_width()   : bits needed to encode "regfile or stage 1..n"
package hazard_unit_param_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } lc3b_hz_state;

  // Forward select encodes 0 (regfile) plus stages 1..num_fwd.
  function automatic int fwd_width(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_param_fwd_match.sv
// One source operand compared against every forwarding stage.
// Ports:
//   src_addr  : source register address
//   src_vld   : source actually reads a register
//   dst_addr  : destination address per stage, stage k at [(k-1)*REG_AW +: REG_AW]
//   dst_wr    : stage k writes the regfile, bit k-1
//   fwd_sel   : 0 = regfile, k = youngest matching stage k
module hazard_fwd_match #(
  parameter int NUM_FWD     = 2,
  parameter int REG_AW      = 3,
  parameter int ZERO_REG_EN = 0,
  parameter int FWD_W       = 2
) (
  input  logic [REG_AW-1:0]         src_addr,
  input  logic                      src_vld,
  input  logic [NUM_FWD*REG_AW-1:0] dst_addr,
  input  logic [NUM_FWD-1:0]        dst_wr,
  output logic [FWD_W-1:0]          fwd_sel
);

  logic zero_blk;

  always_comb begin
    fwd_sel  = '0;
    zero_blk = (ZERO_REG_EN != 0) && (src_addr == '0);
    if (src_vld && !zero_blk) begin
      // Walk oldest to youngest so the youngest (smallest k) match overwrites.
      for (int k = NUM_FWD; k >= 1; k--) begin
        if (dst_wr[k-1] && (dst_addr[(k-1)*REG_AW +: REG_AW] == src_addr)) begin
          fwd_sel = FWD_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit_param.sv
// Operand-hazard unit: forwarding selects for NUM_SRC sources against NUM_FWD
// downstream stages, plus a load-use stall FSM that waits for the memory
// response, honours flush and flags a sticky timeout.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   src_addr/vld : source register addresses (slot s at [s*REG_AW +: REG_AW]) and valids
//   dst_addr/wr  : destination address / regfile-write per stage (stage k at index k-1)
//   mem_rd       : MEM-stage instruction is a load
//   mem_resp     : memory response for the MEM-stage access
//   flush        : pipeline flush
//   fwd_sel      : per source, 0 = regfile, k = forward from stage k
//   stall        : hold IF/ID/EX, bubble into MEM
//   timeout_err  : sticky, MEM_WAIT reached STALL_TMO cycles
//   stall_cnt    : saturating count of stalled cycles
// No valid/ready handshakes here: mem_resp is a single-cycle strobe that
// completes the outstanding stage-1 access in the cycle it is high.
module hazard_unit_param
  import hazard_unit_param_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int NUM_FWD     = 2,
  parameter int REG_AW      = 3,
  parameter int ZERO_REG_EN = 0,
  parameter int STALL_TMO   = 255,
  localparam int FWD_W      = fwd_width(NUM_FWD)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_vld,
  input  logic [NUM_FWD*REG_AW-1:0] dst_addr,
  input  logic [NUM_FWD-1:0]        dst_wr,
  input  logic                      mem_rd,
  input  logic                      mem_resp,
  input  logic                      flush,
  output logic [NUM_SRC*FWD_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic                      timeout_err,
  output logic [31:0]               stall_cnt
);

  localparam int CNT_W = $clog2(STALL_TMO + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(STALL_TMO);

  logic [NUM_SRC*FWD_W-1:0] sel_raw;
  logic [NUM_SRC-1:0]       src_hit1;
  logic                     lu;

  lc3b_hz_state     state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic             stall_c;

  // ---------------- forwarding ----------------
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_fwd_match #(
      .NUM_FWD     (NUM_FWD),
      .REG_AW      (REG_AW),
      .ZERO_REG_EN (ZERO_REG_EN),
      .FWD_W       (FWD_W)
    ) u_match (
      .src_addr (src_addr[s*REG_AW +: REG_AW]),
      .src_vld  (src_vld[s]),
      .dst_addr (dst_addr),
      .dst_wr   (dst_wr),
      .fwd_sel  (sel_raw[s*FWD_W +: FWD_W])
    );
    // Stage 1 is the youngest, so a select of 1 means "matches the MEM stage".
    assign src_hit1[s] = (sel_raw[s*FWD_W +: FWD_W] == FWD_W'(1));
  end

  assign lu      = mem_rd && (|src_hit1);
  assign fwd_sel = rst_n ? sel_raw : '0;

  // ---------------- load-use FSM ----------------
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    stall_c   = 1'b0;
    case (state)
      RUN: begin
        if (lu && !mem_resp && !flush) begin
          stall_c   = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_resp || flush) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          stall_c = 1'b1;
          if (wait_cnt != TMO) wait_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Gated by rst_n so stall drops the instant reset asserts, even if the
  // load-use inputs are still present.
  assign stall = stall_c && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      // Flag on the edge where the wait count reaches the limit.
      if (state_nxt == MEM_WAIT && wait_nxt == TMO) timeout_err <= 1'b1;
      if (stall_c && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_param.sv
module tb_hazard_unit_param;

  logic       clk;
  logic       rst_n;
  logic [5:0] src_addr;
  logic [1:0] src_vld;
  logic [5:0] dst_addr;
  logic [1:0] dst_wr;
  logic       mem_rd, mem_resp, flush;

  logic [3:0]  fwd_sel, fwd_sel_z;
  logic        stall, stall_z;
  logic        timeout_err, timeout_err_z;
  logic [31:0] stall_cnt, stall_cnt_z;

  hazard_unit_param #(
    .NUM_SRC(2), .NUM_FWD(2), .REG_AW(3), .ZERO_REG_EN(0), .STALL_TMO(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_vld(src_vld),
    .dst_addr(dst_addr), .dst_wr(dst_wr), .mem_rd(mem_rd), .mem_resp(mem_resp),
    .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt)
  );

  hazard_unit_param #(
    .NUM_SRC(2), .NUM_FWD(2), .REG_AW(3), .ZERO_REG_EN(1), .STALL_TMO(4)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_vld(src_vld),
    .dst_addr(dst_addr), .dst_wr(dst_wr), .mem_rd(mem_rd), .mem_resp(mem_resp),
    .flush(flush), .fwd_sel(fwd_sel_z), .stall(stall_z), .timeout_err(timeout_err_z),
    .stall_cnt(stall_cnt_z)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, actual %0h", name, act);
    end else begin
      exp = exp_q.pop_front();
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: actual %0h expected %0h", name, act, exp);
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [2:0] s0, s1, input logic [1:0] vld,
                       input logic [2:0] d1, d2, input logic [1:0] wr,
                       input logic mrd, mresp, fl);
    src_addr = {s1, s0};
    src_vld  = vld;
    dst_addr = {d2, d1};
    dst_wr   = wr;
    mem_rd   = mrd;
    mem_resp = mresp;
    flush    = fl;
  endtask

  task automatic drive_idle();
    drive(3'd0, 3'd0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Load in MEM writes r2; source 1 reads r2 -> load-use, source 1 forwards from stage 1.
  task automatic drive_lu(input logic mresp, input logic fl);
    drive(3'd1, 3'd2, 2'b11, 3'd2, 3'd3, 2'b01, 1'b1, mresp, fl);
  endtask

  // One cycle: drive at negedge already done by caller; check stall/timeout/fwd.
  task automatic step_check(input logic exp_st, input logic exp_to, input logic [3:0] exp_fwd);
    expect_val({31'd0, exp_st});
    expect_val({31'd0, exp_to});
    expect_val({28'd0, exp_fwd});
    #1;
    check("stall", {31'd0, stall});
    check("timeout_err", {31'd0, timeout_err});
    check("fwd_sel", {28'd0, fwd_sel});
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [2:0] s0, s1;
    logic [1:0] vld;
    logic [2:0] d1, d2;
    logic [1:0] wr;
    logic       mrd, mresp, fl;
    logic [1:0] f0, f1, fz0, fz1;
    logic       st;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // s0 s1 vld d1 d2 wr mrd mresp fl | f0 f1 fz0 fz1 st
    vecs[0]  = '{3'd3, 3'd5, 2'b11, 3'd3, 3'd5, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 2'd2, 1'b0};
    vecs[1]  = '{3'd4, 3'd0, 2'b01, 3'd4, 3'd4, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd0, 1'b0};
    vecs[2]  = '{3'd4, 3'd0, 2'b01, 3'd4, 3'd4, 2'b10, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0};
    vecs[3]  = '{3'd4, 3'd0, 2'b00, 3'd4, 3'd4, 2'b11, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[4]  = '{3'd6, 3'd6, 2'b11, 3'd1, 3'd6, 2'b11, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 2'd2, 1'b0};
    vecs[5]  = '{3'd7, 3'd0, 2'b11, 3'd0, 3'd2, 2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0};
    vecs[6]  = '{3'd1, 3'd2, 2'b11, 3'd2, 3'd3, 2'b01, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0};
    vecs[7]  = '{3'd1, 3'd2, 2'b11, 3'd2, 3'd3, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0};
    vecs[8]  = '{3'd2, 3'd5, 2'b11, 3'd4, 3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0};
    vecs[9]  = '{3'd2, 3'd2, 2'b00, 3'd2, 3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[10] = '{3'd0, 3'd0, 2'b11, 3'd0, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive_lu(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_val(32'd0); expect_val(32'd0); expect_val(32'd0); expect_val(32'd0);
    #1;
    check("rst_stall", {31'd0, stall});
    check("rst_fwd_sel", {28'd0, fwd_sel});
    check("rst_stall_cnt", stall_cnt);
    check("rst_timeout", {31'd0, timeout_err});
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();

    // ---------------- table vectors ----------------
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].s0, vecs[i].s1, vecs[i].vld, vecs[i].d1, vecs[i].d2, vecs[i].wr,
            vecs[i].mrd, vecs[i].mresp, vecs[i].fl);
      expect_val({28'd0, vecs[i].f1, vecs[i].f0});
      expect_val({31'd0, vecs[i].st});
      expect_val({28'd0, vecs[i].fz1, vecs[i].fz0});
      #1;
      check($sformatf("vec%0d_fwd", i), {28'd0, fwd_sel});
      check($sformatf("vec%0d_stall", i), {31'd0, stall});
      check($sformatf("vec%0d_fwd_z", i), {28'd0, fwd_sel_z});
    end
    @(negedge clk);
    drive_idle();
    expect_val(32'd0);
    expect_val(32'd0);
    #1;
    check("table_stall_cnt", stall_cnt);
    check("table_idle_stall", {31'd0, stall});

    // ---------------- load-use waiting for response ----------------
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_lu(1'b0, 1'b0);
      step_check(1'b1, 1'b0, 4'b0100);
    end
    @(negedge clk);
    drive_lu(1'b1, 1'b0);
    step_check(1'b0, 1'b0, 4'b0100);
    @(negedge clk);
    drive_idle();
    expect_val(32'd3);
    #1;
    check("lu_stall_cnt", stall_cnt);
    step_check(1'b0, 1'b0, 4'b0000);

    // ---------------- flush while in MEM_WAIT ----------------
    @(negedge clk);
    drive_lu(1'b0, 1'b0);
    step_check(1'b1, 1'b0, 4'b0100);
    @(negedge clk);
    drive_lu(1'b0, 1'b1);
    step_check(1'b0, 1'b0, 4'b0100);
    @(negedge clk);
    drive_idle();
    step_check(1'b0, 1'b0, 4'b0000);
    expect_val(32'd4);
    check("flush_stall_cnt", stall_cnt);

    // ---------------- timeout (STALL_TMO=4) ----------------
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive_lu(1'b0, 1'b0);
      step_check(1'b1, (c == 5) ? 1'b1 : 1'b0, 4'b0100);
    end
    @(negedge clk);
    drive_lu(1'b1, 1'b0);
    step_check(1'b0, 1'b1, 4'b0100);
    @(negedge clk);
    drive_idle();
    step_check(1'b0, 1'b1, 4'b0000);
    expect_val(32'd9);
    check("tmo_stall_cnt", stall_cnt);

    // ---------------- reset in the middle of MEM_WAIT ----------------
    @(negedge clk);
    drive_lu(1'b0, 1'b0);
    step_check(1'b1, 1'b1, 4'b0100);
    @(negedge clk);
    step_check(1'b1, 1'b1, 4'b0100);
    #2;
    rst_n = 1'b0;
    expect_val(32'd0); expect_val(32'd0); expect_val(32'd0); expect_val(32'd0);
    #1;
    check("midrst_stall", {31'd0, stall});
    check("midrst_fwd_sel", {28'd0, fwd_sel});
    check("midrst_stall_cnt", stall_cnt);
    check("midrst_timeout", {31'd0, timeout_err});
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    step_check(1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    drive_idle();
    expect_val(32'd0);
    #1;
    check("post_rst_stall_cnt", stall_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
